// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
// Shared definitions for the JESD204 transport-layer ADC capture control.
// Holds the capture FSM state encodings and the width of the debug state port.
package ad_ip_jesd204_tpl_adc_pkg;

    localparam int FSM_DEBUG_WIDTH = 3;

    typedef enum logic [FSM_DEBUG_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DONE     = 3'd4
    } capture_state_e;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Capture sequencer: arm, optional external trigger, frame alignment on SOF,
// then gate adc_valid for a fixed number of valid beats or until disarmed.
module ad_ip_jesd204_tpl_adc_capture_ctrl
    import ad_ip_jesd204_tpl_adc_pkg::*;
#(
    parameter int OCTETS_PER_BEAT = 4,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       ext_sync_en,
    input  logic [COUNT_WIDTH-1:0]     capture_len,
    input  logic                       adc_sync_in,
    input  logic                       link_valid,
    input  logic [OCTETS_PER_BEAT-1:0] link_sof,
    output logic                       capture_en,
    output logic                       adc_rst_sync,
    output logic                       capture_done,
    output logic                       armed,
    output logic [COUNT_WIDTH-1:0]     beat_count,
    output logic [FSM_DEBUG_WIDTH-1:0] fsm_debug
);

    capture_state_e         state_q;
    logic                   sync_prev_q;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   capture_en_q;
    logic                   rst_sync_q;
    logic                   done_q;

    logic                   trigger_d;
    logic                   sof_d;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   unused_sof;

    // Lane 0 carries the beat-aligned frame start; the other lanes are not needed here.
    assign sof_d      = link_valid && link_sof[0];
    assign unused_sof = ^link_sof;

    assign trigger_d = !ext_sync_en || (adc_sync_in && !sync_prev_q);

    // Saturating increment so a continuous capture never wraps the count.
    assign count_d = (&count_q) ? count_q
                                : count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync_prev_q  <= 1'b1;
            len_q        <= '0;
            count_q      <= '0;
            capture_en_q <= 1'b0;
            rst_sync_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync_prev_q <= adc_sync_in;
            rst_sync_q  <= 1'b0;
            done_q      <= 1'b0;
            if (disarm) begin
                state_q      <= ST_IDLE;
                capture_en_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm) begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trigger_d) begin
                            state_q    <= ST_WAIT_SOF;
                            rst_sync_q <= 1'b1;
                        end
                    end
                    ST_WAIT_SOF: begin
                        if (sof_d) begin
                            state_q      <= ST_CAPTURE;
                            capture_en_q <= 1'b1;
                            count_q      <= '0;
                            len_q        <= capture_len;
                        end
                    end
                    ST_CAPTURE: begin
                        if (link_valid) begin
                            count_q <= count_d;
                            if ((len_q != '0) && (count_d == len_q)) begin
                                state_q      <= ST_DONE;
                                capture_en_q <= 1'b0;
                                done_q       <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        capture_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign capture_en   = capture_en_q;
    assign adc_rst_sync = rst_sync_q;
    assign capture_done = done_q;
    assign armed        = (state_q == ST_ARMED) || (state_q == ST_WAIT_SOF);
    assign beat_count   = count_q;
    assign fsm_debug    = state_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Scoreboard bench for the capture controller: each capture window ends in a
// record (enable cycles, alignment pulses, done pulses, final count, state).
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

    localparam int OPB = 4;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           arm;
    logic           disarm;
    logic           ext_sync_en;
    logic [CW-1:0]  capture_len;
    logic           adc_sync_in;
    logic           link_valid;
    logic [OPB-1:0] link_sof;
    logic           capture_en;
    logic           adc_rst_sync;
    logic           capture_done;
    logic           armed;
    logic [CW-1:0]  beat_count;
    logic [2:0]     fsm_debug;

    ad_ip_jesd204_tpl_adc_capture_ctrl #(
        .OCTETS_PER_BEAT(OPB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .disarm      (disarm),
        .ext_sync_en (ext_sync_en),
        .capture_len (capture_len),
        .adc_sync_in (adc_sync_in),
        .link_valid  (link_valid),
        .link_sof    (link_sof),
        .capture_en  (capture_en),
        .adc_rst_sync(adc_rst_sync),
        .capture_done(capture_done),
        .armed       (armed),
        .beat_count  (beat_count),
        .fsm_debug   (fsm_debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int rst;
        int done;
        int cnt;
        int fsm;
    } rec_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc_en   = 0;
    int   acc_rst  = 0;
    int   acc_done = 0;
    logic prev_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push_exp(input int en, input int rst, input int done, input int cnt, input int fsm);
        rec_t r;
        r.en = en; r.rst = rst; r.done = done; r.cnt = cnt; r.fsm = fsm;
        exp_q.push_back(r);
    endtask

    // Monitor: accumulate per-window activity, compare when capture_en falls.
    always @(negedge clk) begin
        rec_t e;
        acc_rst  += int'(adc_rst_sync);
        acc_done += int'(capture_done);
        if (capture_en) acc_en++;
        if (prev_en && !capture_en) begin
            $display("TXN capture en_cycles=%0d rst_pulses=%0d done_pulses=%0d beat_count=%0d state=%0d",
                     acc_en, acc_rst, acc_done, beat_count, fsm_debug);
            if (exp_q.size() == 0) begin
                chk("unexpected_capture_end", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("en_cycles",   acc_en,          e.en);
                chk("rst_pulses",  acc_rst,         e.rst);
                chk("done_pulses", acc_done,        e.done);
                chk("beat_count",  int'(beat_count), e.cnt);
                chk("end_state",   int'(fsm_debug), e.fsm);
            end
            acc_en = 0; acc_rst = 0; acc_done = 0;
        end
        prev_en = capture_en;
    end

    task automatic cyc(input logic v, input logic [OPB-1:0] s);
        link_valid = v;
        link_sof   = s;
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_capture_en",   int'(capture_en),   0);
        chk("rst_adc_rst_sync", int'(adc_rst_sync), 0);
        chk("rst_capture_done", int'(capture_done), 0);
        chk("rst_armed",        int'(armed),        0);
        chk("rst_beat_count",   int'(beat_count),   0);
        chk("rst_fsm",          int'(fsm_debug),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1; arm = 1'b0; disarm = 1'b0; ext_sync_en = 1'b0;
        capture_len = '0; adc_sync_in = 1'b0; link_valid = 1'b0; link_sof = '0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b0;
        cyc(0, 4'b0000);

        // Immediate trigger, 8-beat capture, SOF every 4 beats.
        capture_len = 4'd8; ext_sync_en = 1'b0;
        push_exp(8, 1, 1, 8, 4);
        for (int i = 0; i < 24; i++) begin
            arm = (i == 0);
            cyc(1, (i % 4 == 0) ? 4'b0001 : 4'b0000);
        end
        arm = 1'b0;
        chk("t1_hold_count", int'(beat_count), 8);
        chk("t1_idle",       int'(fsm_debug),  0);

        // External trigger held low for 50 cycles, then a rising edge.
        ext_sync_en = 1'b1; adc_sync_in = 1'b0; capture_len = 4'd3;
        push_exp(3, 1, 1, 3, 4);
        arm = 1'b1; cyc(1, 4'b0000); arm = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1, 4'b0001);
            if (fsm_debug != 3'd1 || !armed) bad++;
        end
        chk("t2_armed_hold_bad_cycles", bad, 0);
        adc_sync_in = 1'b1;
        cyc(1, 4'b0000);
        chk("t2_wait_sof",     int'(fsm_debug),    2);
        chk("t2_armed",        int'(armed),        1);
        chk("t2_adc_rst_sync", int'(adc_rst_sync), 1);
        cyc(1, 4'b0010);
        chk("t2_lane1_sof_ignored", int'(fsm_debug),    2);
        chk("t2_rst_one_cycle",     int'(adc_rst_sync), 0);
        cyc(0, 4'b0001);
        chk("t2_invalid_sof_ignored", int'(fsm_debug), 2);
        cyc(1, 4'b0001);
        chk("t2_capture",    int'(fsm_debug),  3);
        chk("t2_capture_en", int'(capture_en), 1);
        repeat (5) cyc(1, 4'b0000);
        adc_sync_in = 1'b0;
        ext_sync_en = 1'b0;

        // Gapped link_valid: 4 beats over 7 capture cycles.
        capture_len = 4'd4;
        push_exp(7, 1, 1, 4, 4);
        arm = 1'b1; cyc(0, 4'b0000); arm = 1'b0;
        cyc(0, 4'b0000);
        cyc(1, 4'b0001);
        for (int i = 0; i < 7; i++) cyc(((i % 2) == 0), 4'b0000);
        repeat (3) cyc(0, 4'b0000);

        // Continuous capture saturates at 15, disarm gives no done pulse.
        capture_len = 4'd0;
        push_exp(21, 1, 0, 15, 0);
        arm = 1'b1; cyc(0, 4'b0000); arm = 1'b0;
        cyc(0, 4'b0000);
        cyc(1, 4'b0001);
        repeat (20) cyc(1, 4'b0000);
        disarm = 1'b1; cyc(1, 4'b0001); disarm = 1'b0;
        chk("t4_disarm_idle", int'(fsm_debug), 0);
        repeat (3) cyc(0, 4'b0000);

        // Arm and disarm together: disarm wins.
        arm = 1'b1; disarm = 1'b1; cyc(0, 4'b0000); arm = 1'b0; disarm = 1'b0;
        chk("t6_arm_disarm_idle",  int'(fsm_debug), 0);
        chk("t6_arm_disarm_armed", int'(armed),     0);
        cyc(0, 4'b0000);
        chk("t6_still_idle", int'(fsm_debug), 0);

        // Arm during capture is ignored; length is latched on capture entry.
        capture_len = 4'd5;
        push_exp(5, 1, 1, 5, 4);
        arm = 1'b1; cyc(0, 4'b0000); arm = 1'b0;
        cyc(0, 4'b0000);
        cyc(1, 4'b0001);
        capture_len = 4'd3;
        cyc(1, 4'b0000);
        cyc(1, 4'b0000);
        arm = 1'b1; cyc(1, 4'b0000); arm = 1'b0;
        cyc(1, 4'b0000);
        cyc(1, 4'b0000);
        repeat (3) cyc(0, 4'b0000);
        chk("t6_idle_after_done", int'(fsm_debug), 0);

        // Reset mid-capture aborts with no done pulse and clears the count.
        capture_len = 4'd0;
        push_exp(4, 1, 0, 0, 0);
        arm = 1'b1; cyc(0, 4'b0000); arm = 1'b0;
        cyc(0, 4'b0000);
        cyc(1, 4'b0001);
        repeat (3) cyc(1, 4'b0000);
        adc_sync_in = 1'b1;
        reset = 1'b1;
        repeat (3) cyc(1, 4'b0000);
        chk_reset_state();
        reset = 1'b0;

        // Trigger high through reset release needs a fresh rising edge.
        ext_sync_en = 1'b1; capture_len = 4'd2;
        push_exp(2, 1, 1, 2, 4);
        arm = 1'b1; cyc(0, 4'b0000); arm = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 4'b0001);
            if (fsm_debug != 3'd1) bad++;
        end
        chk("t7_no_edge_while_high", bad, 0);
        adc_sync_in = 1'b0;
        cyc(0, 4'b0000);
        chk("t7_falling_no_trigger", int'(fsm_debug), 1);
        adc_sync_in = 1'b1;
        cyc(0, 4'b0000);
        chk("t7_rise_trigger", int'(fsm_debug), 2);
        cyc(1, 4'b0001);
        repeat (2) cyc(1, 4'b0000);
        repeat (4) cyc(0, 4'b0000);

        chk("pending_expected_records", exp_q.size(), 0);
        chk("stray_done_pulses",        acc_done,     0);
        chk("stray_rst_pulses",         acc_rst,      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
